// File: rtl/mem_stage_ooo_ret.sv
// MEM stage holding a memory op until its in-order data_ok returns.
// Optional ID forwarding port enabled by `define MEM_FWD_EN.
module mem_stage_ooo_ret #(
  parameter int PAYLOAD_W = 160,
  parameter int DISCARD_W = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 ex_to_mem_valid,
  output logic                 mem_allowin,
  input  logic [PAYLOAD_W-1:0] ex_payload,
  input  logic                 ex_rf_we,
  input  logic [4:0]           ex_rf_waddr,
  input  logic [31:0]          ex_alu_result,
  input  logic                 ex_wait_ok,
  input  logic                 ex_is_load,
  input  logic [1:0]           ex_ld_size,
  input  logic                 ex_ld_unsigned,
  input  logic [1:0]           ex_addr_lo,
  input  logic                 wb_allowin,
  output logic                 mem_to_wb_valid,
  output logic [PAYLOAD_W-1:0] mem_to_wb_payload,
  output logic                 mem_to_wb_rf_we,
  output logic [4:0]           mem_to_wb_rf_waddr,
  output logic [31:0]          mem_to_wb_rf_wdata,
  input  logic                 data_sram_data_ok,
  input  logic [31:0]          data_sram_rdata,
  input  logic                 flush,
  output logic                 discard_busy,
  output logic                 mem_fwd_we,
  output logic [4:0]           mem_fwd_waddr,
  output logic [31:0]          mem_fwd_wdata,
  output logic                 mem_fwd_data_ok
);

  typedef struct packed {
    logic [PAYLOAD_W-1:0] payload;
    logic                 rf_we;
    logic [4:0]           rf_waddr;
    logic [31:0]          alu_result;
    logic                 wait_ok;
    logic                 is_load;
    logic [1:0]           ld_size;
    logic                 ld_unsigned;
    logic [1:0]           addr_lo;
  } stage_t;

  localparam int CW = DISCARD_W + 2;
  localparam logic [DISCARD_W-1:0] CNT_MAX = '1;

  stage_t               st_q, st_d;
  logic                 mem_valid_q, mem_valid_d;
  logic                 got_q, got_d;
  logic [31:0]          hold_data_q, hold_data_d;
  logic [DISCARD_W-1:0] discard_cnt_q, discard_cnt_d;

  logic          cnt_nz;
  logic          dec;
  logic          accept_ok;
  logic          ready_go;
  logic          load_en;
  logic          inc_mem;
  logic          inc_ex;
  logic [CW-1:0] cnt_sum;
  logic [31:0]   src;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   ld_data;
  logic [31:0]   wdata;

  // Response routing and pipeline handshake
  always_comb begin
    cnt_nz    = |discard_cnt_q;
    dec       = data_sram_data_ok & cnt_nz;
    accept_ok = data_sram_data_ok & ~cnt_nz & mem_valid_q
              & st_q.wait_ok & ~got_q;
    ready_go  = ~st_q.wait_ok | got_q | accept_ok;
    mem_allowin     = ~mem_valid_q | (ready_go & wb_allowin);
    mem_to_wb_valid = mem_valid_q & ready_go;
    load_en   = ex_to_mem_valid & mem_allowin;
    discard_busy = cnt_nz;
  end

  // Load data select and extension, zero-cycle from data_ok
  always_comb begin
    src = got_q ? hold_data_q : data_sram_rdata;
    unique case (st_q.addr_lo)
      2'd0:    byte_sel = src[7:0];
      2'd1:    byte_sel = src[15:8];
      2'd2:    byte_sel = src[23:16];
      default: byte_sel = src[31:24];
    endcase
    half_sel = st_q.addr_lo[1] ? src[31:16] : src[15:0];
    unique case (st_q.ld_size)
      2'd0:
        ld_data = {{24{byte_sel[7] & ~st_q.ld_unsigned}},
                   byte_sel};
      2'd1:
        ld_data = {{16{half_sel[15] & ~st_q.ld_unsigned}},
                   half_sel};
      default: ld_data = src;
    endcase
    wdata = st_q.is_load ? ld_data : st_q.alu_result;
    mem_to_wb_payload  = st_q.payload;
    mem_to_wb_rf_we    = st_q.rf_we & mem_valid_q;
    mem_to_wb_rf_waddr = st_q.rf_waddr;
    mem_to_wb_rf_wdata = wdata;
  end

  // Next state: stage regs, early-response hold, discard counter
  always_comb begin
    st_d        = st_q;
    mem_valid_d = mem_valid_q;
    got_d       = got_q;
    hold_data_d = hold_data_q;
    if (load_en) begin
      st_d.payload     = ex_payload;
      st_d.rf_we       = ex_rf_we;
      st_d.rf_waddr    = ex_rf_waddr;
      st_d.alu_result  = ex_alu_result;
      st_d.wait_ok     = ex_wait_ok;
      st_d.is_load     = ex_is_load;
      st_d.ld_size     = ex_ld_size;
      st_d.ld_unsigned = ex_ld_unsigned;
      st_d.addr_lo     = ex_addr_lo;
    end
    if (flush) begin
      mem_valid_d = 1'b0;
      got_d       = 1'b0;
    end else if (mem_allowin) begin
      mem_valid_d = ex_to_mem_valid;
      got_d       = 1'b0;
    end else if (accept_ok & ~wb_allowin) begin
      got_d       = 1'b1;
      hold_data_d = data_sram_rdata;
    end
    inc_mem = mem_valid_q & st_q.wait_ok & ~got_q & ~accept_ok;
    inc_ex  = ex_to_mem_valid & ex_wait_ok;
    cnt_sum = CW'(discard_cnt_q) - CW'(dec);
    if (flush)
      cnt_sum = cnt_sum + CW'(inc_mem) + CW'(inc_ex);
    if (cnt_sum > CW'(CNT_MAX))
      discard_cnt_d = CNT_MAX;
    else
      discard_cnt_d = cnt_sum[DISCARD_W-1:0];
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      st_q          <= '0;
      mem_valid_q   <= 1'b0;
      got_q         <= 1'b0;
      hold_data_q   <= '0;
      discard_cnt_q <= '0;
    end else begin
      st_q          <= st_d;
      mem_valid_q   <= mem_valid_d;
      got_q         <= got_d;
      hold_data_q   <= hold_data_d;
      discard_cnt_q <= discard_cnt_d;
    end
  end

`ifdef MEM_FWD_EN
  // Forwarding to ID; data_ok low tells ID to stall
  always_comb begin
    mem_fwd_we      = st_q.rf_we & mem_valid_q;
    mem_fwd_waddr   = st_q.rf_waddr;
    mem_fwd_wdata   = wdata;
    mem_fwd_data_ok = mem_valid_q
                    & (~(st_q.is_load & st_q.wait_ok)
                       | got_q | accept_ok);
  end
`else
  // No forwarding; ID resolves MEM hazards by scoreboard
  always_comb begin
    mem_fwd_we      = 1'b0;
    mem_fwd_waddr   = 5'd0;
    mem_fwd_wdata   = 32'd0;
    mem_fwd_data_ok = 1'b0;
  end
`endif

endmodule

// File: tb/tb_mem_stage_ooo_ret.sv
// Random bench for mem_stage_ooo_ret against a queue-based model
// of owed data_sram responses.
module tb_mem_stage_ooo_ret;

  localparam int PW = 160;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          resetn;
  logic          ex_to_mem_valid;
  logic          mem_allowin;
  logic [PW-1:0] ex_payload;
  logic          ex_rf_we;
  logic [4:0]    ex_rf_waddr;
  logic [31:0]   ex_alu_result;
  logic          ex_wait_ok;
  logic          ex_is_load;
  logic [1:0]    ex_ld_size;
  logic          ex_ld_unsigned;
  logic [1:0]    ex_addr_lo;
  logic          wb_allowin;
  logic          mem_to_wb_valid;
  logic [PW-1:0] mem_to_wb_payload;
  logic          mem_to_wb_rf_we;
  logic [4:0]    mem_to_wb_rf_waddr;
  logic [31:0]   mem_to_wb_rf_wdata;
  logic          data_sram_data_ok;
  logic [31:0]   data_sram_rdata;
  logic          flush;
  logic          discard_busy;
  logic          mem_fwd_we;
  logic [4:0]    mem_fwd_waddr;
  logic [31:0]   mem_fwd_wdata;
  logic          mem_fwd_data_ok;

  mem_stage_ooo_ret #(.PAYLOAD_W(PW), .DISCARD_W(2)) dut (
    .clk                (clk),
    .resetn             (resetn),
    .ex_to_mem_valid    (ex_to_mem_valid),
    .mem_allowin        (mem_allowin),
    .ex_payload         (ex_payload),
    .ex_rf_we           (ex_rf_we),
    .ex_rf_waddr        (ex_rf_waddr),
    .ex_alu_result      (ex_alu_result),
    .ex_wait_ok         (ex_wait_ok),
    .ex_is_load         (ex_is_load),
    .ex_ld_size         (ex_ld_size),
    .ex_ld_unsigned     (ex_ld_unsigned),
    .ex_addr_lo         (ex_addr_lo),
    .wb_allowin         (wb_allowin),
    .mem_to_wb_valid    (mem_to_wb_valid),
    .mem_to_wb_payload  (mem_to_wb_payload),
    .mem_to_wb_rf_we    (mem_to_wb_rf_we),
    .mem_to_wb_rf_waddr (mem_to_wb_rf_waddr),
    .mem_to_wb_rf_wdata (mem_to_wb_rf_wdata),
    .data_sram_data_ok  (data_sram_data_ok),
    .data_sram_rdata    (data_sram_rdata),
    .flush              (flush),
    .discard_busy       (discard_busy),
    .mem_fwd_we         (mem_fwd_we),
    .mem_fwd_waddr      (mem_fwd_waddr),
    .mem_fwd_wdata      (mem_fwd_wdata),
    .mem_fwd_data_ok    (mem_fwd_data_ok)
  );

  typedef struct {
    logic [PW-1:0] pl;
    logic          we;
    logic [4:0]    wa;
    logic [31:0]   alu;
    logic          wt;
    logic          ld;
    logic [1:0]    sz;
    logic          un;
    logic [1:0]    lo;
    int            id;
  } ins_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [PW-1:0] got,
                     input logic [PW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h exp %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  // model state: MEM slot, EX slot, owed responses (-1 = orphan)
  ins_t        m, ex;
  bit          m_v, m_got, ex_v;
  logic [31:0] m_hold;
  int          q[$];
  int          next_id = 1;

  function automatic logic [31:0] ld_val(input ins_t i,
                                         input logic [31:0] s);
    logic [31:0] v;
    if (!i.ld) return i.alu;
    if (i.sz == 2'd0) begin
      v = (s >> (8 * i.lo)) & 32'hFF;
      if (!i.un && v >= 32'h80) v = v - 32'h100;
    end else if (i.sz == 2'd1) begin
      v = (s >> (8 * i.lo)) & 32'hFFFF;
      if (!i.un && v >= 32'h8000) v = v - 32'h10000;
    end else begin
      v = s;
    end
    return v;
  endfunction

  function automatic int orphans();
    int n = 0;
    foreach (q[k]) if (q[k] == -1) n++;
    return n;
  endfunction

  task automatic gen_ex();
    int kind;
    if (ex_v || $urandom_range(0, 3) == 0) return;
    kind = $urandom_range(0, 2);
    if (kind != 0 && q.size() >= 3) kind = 0;
    ex.pl  = {$urandom, $urandom, $urandom, $urandom, $urandom};
    ex.wa  = 5'($urandom);
    ex.alu = $urandom;
    ex.un  = 1'($urandom);
    ex.sz  = 2'($urandom_range(0, 2));
    ex.lo  = 2'($urandom);
    if (ex.sz == 2'd1) ex.lo[0] = 1'b0;
    if (ex.sz == 2'd2) ex.lo = 2'd0;
    ex.wt  = (kind != 0);
    ex.ld  = (kind == 1);
    ex.we  = (kind == 1) ? 1'b1 : (kind == 2) ? 1'b0 : 1'($urandom);
    ex.id  = next_id++;
    if (ex.wt) q.push_back(ex.id);
    ex_v = 1;
  endtask

  task automatic drive_ex();
    ex_to_mem_valid = ex_v;
    ex_payload      = ex.pl;
    ex_rf_we        = ex.we;
    ex_rf_waddr     = ex.wa;
    ex_alu_result   = ex.alu;
    ex_wait_ok      = ex.wt;
    ex_is_load      = ex.ld;
    ex_ld_size      = ex.sz;
    ex_ld_unsigned  = ex.un;
    ex_addr_lo      = ex.lo;
  endtask

  initial begin
    bit          can_rsp, dok, wb_a, fl, acc, rdy, alw;
    logic [31:0] rd, exp_wd;
    int          orph;

    ex = '{default: 0};
    m  = '{default: 0};
    m_v = 0; m_got = 0; ex_v = 0; m_hold = '0;
    resetn = 1'b0;
    drive_ex();
    wb_allowin = 1'b0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata = '0;
    flush = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_allowin", PW'(mem_allowin), PW'(1));
    chk("rst_wb_valid", PW'(mem_to_wb_valid), '0);
    chk("rst_payload", mem_to_wb_payload, '0);
    chk("rst_rf_we", PW'(mem_to_wb_rf_we), '0);
    chk("rst_waddr", PW'(mem_to_wb_rf_waddr), '0);
    chk("rst_wdata", PW'(mem_to_wb_rf_wdata), '0);
    chk("rst_busy", PW'(discard_busy), '0);
    chk("rst_fwd", PW'({mem_fwd_we, mem_fwd_waddr,
                        mem_fwd_wdata, mem_fwd_data_ok}), '0);
    resetn = 1'b1;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      gen_ex();
      wb_a = ($urandom_range(0, 9) < 7);
      fl   = ($urandom_range(0, 29) == 0);
      can_rsp = (q.size() > 0) &&
                (q[0] == -1 || (m_v && !m_got && q[0] == m.id));
      dok  = can_rsp && ($urandom_range(0, 1) == 1);
      rd   = $urandom;
      drive_ex();
      wb_allowin        = wb_a;
      flush             = fl;
      data_sram_data_ok = dok;
      data_sram_rdata   = rd;
      #1;
      orph = orphans();
      acc  = dok && orph == 0 && m_v && m.wt && !m_got;
      rdy  = !m.wt || m_got || acc;
      alw  = !m_v || (rdy && wb_a);
      chk("allowin", PW'(mem_allowin), PW'(alw));
      chk("wb_valid", PW'(mem_to_wb_valid), PW'(m_v && rdy));
      chk("rf_we", PW'(mem_to_wb_rf_we), PW'(m_v && m.we));
      chk("busy", PW'(discard_busy), PW'(orph != 0));
      exp_wd = ld_val(m, m_got ? m_hold : rd);
      if (m_v) chk("waddr", PW'(mem_to_wb_rf_waddr), PW'(m.wa));
      if (m_v && rdy) begin
        chk("wdata", PW'(mem_to_wb_rf_wdata), PW'(exp_wd));
        chk("payload", mem_to_wb_payload, m.pl);
      end
`ifdef MEM_FWD_EN
      chk("fwd_we", PW'(mem_fwd_we), PW'(m_v && m.we));
      chk("fwd_ok", PW'(mem_fwd_data_ok),
          PW'(m_v && (!(m.ld && m.wt) || m_got || acc)));
      if (m_v) chk("fwd_waddr", PW'(mem_fwd_waddr), PW'(m.wa));
      if (m_v && rdy)
        chk("fwd_wdata", PW'(mem_fwd_wdata), PW'(exp_wd));
`else
      chk("fwd_off", PW'({mem_fwd_we, mem_fwd_waddr,
                          mem_fwd_wdata, mem_fwd_data_ok}), '0);
`endif
      if (dok) void'(q.pop_front());
      if (fl) begin
        foreach (q[k]) q[k] = -1;
        m_v = 0; m_got = 0; ex_v = 0;
      end else begin
        if (acc && !wb_a) begin
          m_got = 1;
          m_hold = rd;
        end
        if (alw) begin
          m_v = ex_v;
          m = ex;
          m_got = 0;
          ex_v = 0;
        end
      end
      assert (orphans() <= 3)
        else $error("orphan count exceeds counter range");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
